decode_stage: RTL and testbench

- Instruction-decode stage and ID/EX pipeline register. Sits directly upstream of the execute ALU and feeds it Operand1, Operand2 and the 5-bit Operation code.
- Holds the 32x32 integer register file. Decodes RV32I instructions, selects operands and produces downstream control.
- Outputs are registered once per accepted instruction. Supports stall, flush and writeback-to-decode bypass.

---
 rtl/decode_stage_if.sv | 44 ++++
 rtl/decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch, writeback and ID/EX bundle around the decode stage.
// The master side is whoever drives fetch/writeback and consumes the ID/EX outputs.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            stall;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            id_ready;
  logic            ex_valid;
  logic [XLEN-1:0] Operand1;
  logic [XLEN-1:0] Operand2;
  logic [4:0]      Operation;
  logic [4:0]      ex_rd;
  logic            ex_reg_we;
  logic            ex_mem_rd;
  logic            ex_mem_wr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            ex_is_jal;
  logic            ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, stall, flush, wb_we, wb_rd, wb_data,
    input  id_ready, ex_valid, Operand1, Operand2, Operation, ex_rd, ex_reg_we,
           ex_mem_rd, ex_mem_wr, ex_funct3, ex_store_data, ex_pc, ex_imm,
           ex_is_jal, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, stall, flush, wb_we, wb_rd, wb_data,
    output id_ready, ex_valid, Operand1, Operand2, Operation, ex_rd, ex_reg_we,
           ex_mem_rd, ex_mem_wr, ex_funct3, ex_store_data, ex_pc, ex_imm,
           ex_is_jal, ex_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with writeback bypass, instruction decode,
// and the ID/EX pipeline register feeding the execute ALU.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd13;
  localparam logic [4:0] OPN_BRANCH = 5'd16;
  localparam logic [4:0] OPN_LUI    = 5'd24;
  localparam logic [4:0] OPN_JALR   = 5'd25;

  typedef struct packed {
    logic            valid;
    logic            reg_we;
    logic            mem_rd;
    logic            mem_wr;
    logic            is_jal;
    logic            illegal;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      operation;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } idex_t;

  logic [XLEN-1:0] regs [NREGS];
  idex_t           ex_q;
  idex_t           dec;

  logic [31:0]     instr;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic            wb_fire;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]      alu_op;

  assign instr     = bus.if_instr;
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign funct7_b5 = instr[30];

  // x0 is never written, so a plain array read already returns zero for it.
  assign wb_fire = bus.wb_we && (bus.wb_rd != 5'd0);
  assign rs1_val = (wb_fire && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
  assign rs2_val = (wb_fire && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = XLEN'({instr[31:12], 12'b0});
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // funct7[5] means SUB only for register-register ops; OP-IMM never subtracts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (instr[6:0] == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = 5'd1;
      3'b010:  alu_op = 5'd2;
      3'b011:  alu_op = 5'd6;
      3'b100:  alu_op = 5'd4;
      3'b101:  alu_op = funct7_b5 ? ALU_SRA : 5'd5;
      3'b110:  alu_op = 5'd3;
      3'b111:  alu_op = 5'd7;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    dec            = '0;
    dec.valid      = 1'b1;
    dec.rd         = rd;
    dec.funct3     = funct3;
    dec.pc         = bus.if_pc;
    dec.store_data = rs2_val;
    case (instr[6:0])
      OPC_OP: begin
        dec.operation = alu_op;
        dec.op1       = rs1_val;
        dec.op2       = rs2_val;
        dec.reg_we    = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.operation = alu_op;
        dec.op1       = rs1_val;
        dec.op2       = (funct3[1:0] == 2'b01) ? {{(XLEN-5){1'b0}}, instr[24:20]} : imm_i;
        dec.imm       = imm_i;
        dec.reg_we    = 1'b1;
      end
      OPC_LOAD: begin
        dec.op1    = rs1_val;
        dec.op2    = imm_i;
        dec.imm    = imm_i;
        dec.mem_rd = 1'b1;
        dec.reg_we = 1'b1;
      end
      OPC_STORE: begin
        dec.op1    = rs1_val;
        dec.op2    = imm_s;
        dec.imm    = imm_s;
        dec.mem_wr = 1'b1;
      end
      OPC_BRANCH: begin
        dec.operation = OPN_BRANCH | {2'b00, funct3};
        dec.op1       = rs1_val;
        dec.op2       = rs2_val;
        dec.imm       = imm_b;
        dec.illegal   = (funct3[2:1] == 2'b01);
      end
      OPC_LUI: begin
        dec.operation = OPN_LUI;
        dec.op2       = imm_u;
        dec.imm       = imm_u;
        dec.reg_we    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1    = bus.if_pc;
        dec.op2    = imm_u;
        dec.imm    = imm_u;
        dec.reg_we = 1'b1;
      end
      OPC_JAL: begin
        dec.op1    = bus.if_pc;
        dec.op2    = XLEN'(4);
        dec.imm    = imm_j;
        dec.is_jal = 1'b1;
        dec.reg_we = 1'b1;
      end
      OPC_JALR: begin
        dec.operation = OPN_JALR;
        dec.op1       = rs1_val;
        dec.op2       = imm_i;
        dec.imm       = imm_i;
        dec.reg_we    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec.reg_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
      // NOTE: the register file is cleared on reset, so it must stay flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wb_fire) regs[bus.wb_rd] <= bus.wb_data;
      // A bubble only needs to kill the control bits; the datapath fields are don't-care.
      if (bus.flush || (!bus.stall && !bus.if_valid)) begin
        ex_q.valid   <= 1'b0;
        ex_q.reg_we  <= 1'b0;
        ex_q.mem_rd  <= 1'b0;
        ex_q.mem_wr  <= 1'b0;
        ex_q.is_jal  <= 1'b0;
        ex_q.illegal <= 1'b0;
      end else if (!bus.stall) begin
        ex_q <= dec;
      end
    end
  end

  assign bus.id_ready      = ~bus.stall;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.Operand1      = ex_q.op1;
  assign bus.Operand2      = ex_q.op2;
  assign bus.Operation     = ex_q.operation;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_reg_we     = ex_q.reg_we;
  assign bus.ex_mem_rd     = ex_q.mem_rd;
  assign bus.ex_mem_wr     = ex_q.mem_wr;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_store_data = ex_q.store_data;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_is_jal     = ex_q.is_jal;
  assign bus.ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases with literal expectations plus random
// traffic compared every cycle against an instruction-level model.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit        valid, reg_we, mem_rd, mem_wr, is_jal, illegal;
    bit [31:0] op1, op2, sd, pc, imm;
    bit [4:0]  operation, rd;
    bit [2:0]  f3;
    bit        c_op1, c_op2, c_sd, c_imm, c_rd;
  } exp_t;

  int        n_checks = 0;
  int        n_fail   = 0;
  bit [31:0] mregs [32];
  exp_t      exp_q;
  bit        check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural register read as seen by decode, including the same-cycle writeback.
  function automatic bit [31:0] mread(input bit [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_we && bus.wb_rd == a) return bus.wb_data;
    return mregs[a];
  endfunction

  function automatic bit [4:0] alu_code(input bit [2:0] f3, input bit alt_sub, input bit alt_sra);
    bit [4:0] map [8] = '{5'd0, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5, 5'd3, 5'd7};
    if (f3 == 3'd0 && alt_sub) return 5'd8;
    if (f3 == 3'd5 && alt_sra) return 5'd13;
    return map[f3];
  endfunction

  function automatic exp_t model_decode(input bit [31:0] ins, input bit [31:0] pc);
    exp_t      e     = '{default: 0};
    bit [2:0]  f3    = ins[14:12];
    bit [31:0] r1    = mread(ins[19:15]);
    bit [31:0] r2    = mread(ins[24:20]);
    bit [31:0] imm_i = 32'($signed(ins[31:20]));
    bit [31:0] imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    bit [31:0] imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    bit [31:0] imm_u = {ins[31:12], 12'h000};
    bit [31:0] imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.valid = 1'b1;
    e.pc    = pc;
    e.f3    = f3;
    e.rd    = ins[11:7];
    case (ins[6:0])
      7'b0110011: begin
        e.operation = alu_code(f3, ins[30], ins[30]);
        e.op1 = r1; e.op2 = r2; e.reg_we = 1'b1;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_rd = 1'b1;
      end
      7'b0010011: begin
        e.operation = alu_code(f3, 1'b0, ins[30]);
        e.op1 = r1;
        e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : imm_i;
        e.imm = imm_i; e.reg_we = 1'b1;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_rd = 1'b1;
      end
      7'b0000011: begin
        e.op1 = r1; e.op2 = imm_i; e.imm = imm_i; e.mem_rd = 1'b1; e.reg_we = 1'b1;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_rd = 1'b1;
      end
      7'b0100011: begin
        e.op1 = r1; e.op2 = imm_s; e.imm = imm_s; e.mem_wr = 1'b1; e.sd = r2;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_sd = 1'b1;
      end
      7'b1100011: begin
        e.operation = 5'(16 + f3);
        e.op1 = r1; e.op2 = r2; e.imm = imm_b;
        e.illegal = (f3 == 3'd2 || f3 == 3'd3);
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1;
      end
      7'b0110111: begin
        e.operation = 5'd24; e.op2 = imm_u; e.imm = imm_u; e.reg_we = 1'b1;
        e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_rd = 1'b1;
      end
      7'b0010111: begin
        e.op1 = pc; e.op2 = imm_u; e.imm = imm_u; e.reg_we = 1'b1;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_rd = 1'b1;
      end
      7'b1101111: begin
        e.op1 = pc; e.op2 = 32'd4; e.imm = imm_j; e.is_jal = 1'b1; e.reg_we = 1'b1;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_rd = 1'b1;
      end
      7'b1100111: begin
        e.operation = 5'd25; e.op1 = r1; e.op2 = imm_i; e.imm = imm_i; e.reg_we = 1'b1;
        e.c_op1 = 1'b1; e.c_op2 = 1'b1; e.c_imm = 1'b1; e.c_rd = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.rd == 5'd0) e.reg_we = 1'b0;
    return e;
  endfunction

  // One clock: predict the next ID/EX contents from the inputs now applied, then advance.
  task automatic tick();
    exp_t      nxt   = exp_q;
    bit        rst   = !rst_n;
    bit        do_wr = bus.wb_we && bus.wb_rd != 5'd0;
    bit [4:0]  wa    = bus.wb_rd;
    bit [31:0] wd    = bus.wb_data;
    if (rst) begin
      nxt = '{default: 0};
    end else if (bus.flush || (!bus.stall && !bus.if_valid)) begin
      nxt.valid = 1'b0; nxt.reg_we = 1'b0; nxt.mem_rd = 1'b0;
      nxt.mem_wr = 1'b0; nxt.is_jal = 1'b0; nxt.illegal = 1'b0;
    end else if (!bus.stall) begin
      nxt = model_decode(bus.if_instr, bus.if_pc);
    end
    @(posedge clk);
    exp_q = nxt;
    if (rst) foreach (mregs[i]) mregs[i] = 32'd0;
    else if (do_wr) mregs[wa] = wd;
    check_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic compare();
    check("ex_valid",   32'(bus.ex_valid),   32'(exp_q.valid));
    check("ex_reg_we",  32'(bus.ex_reg_we),  32'(exp_q.reg_we));
    check("ex_mem_rd",  32'(bus.ex_mem_rd),  32'(exp_q.mem_rd));
    check("ex_mem_wr",  32'(bus.ex_mem_wr),  32'(exp_q.mem_wr));
    check("ex_is_jal",  32'(bus.ex_is_jal),  32'(exp_q.is_jal));
    check("ex_illegal", 32'(bus.ex_illegal), 32'(exp_q.illegal));
    check("id_ready",   32'(bus.id_ready),   32'(!bus.stall));
    if (exp_q.valid) begin
      check("Operation", 32'(bus.Operation), 32'(exp_q.operation));
      check("ex_pc",     bus.ex_pc,          exp_q.pc);
      check("ex_funct3", 32'(bus.ex_funct3), 32'(exp_q.f3));
      if (exp_q.c_rd)  check("ex_rd",         32'(bus.ex_rd),    32'(exp_q.rd));
      if (exp_q.c_op1) check("Operand1",      bus.Operand1,      exp_q.op1);
      if (exp_q.c_op2) check("Operand2",      bus.Operand2,      exp_q.op2);
      if (exp_q.c_sd)  check("ex_store_data", bus.ex_store_data, exp_q.sd);
      if (exp_q.c_imm) check("ex_imm",        bus.ex_imm,        exp_q.imm);
    end
  endtask

  always @(negedge clk) if (check_en) compare();

  function automatic bit [31:0] r_add(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic issue(input bit [31:0] ins, input bit [31:0] pc = 32'h40);
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    tick();
  endtask

  task automatic wreg(input bit [4:0] a, input bit [31:0] d);
    bus.if_valid = 1'b0;
    bus.wb_we    = 1'b1;
    bus.wb_rd    = a;
    bus.wb_data  = d;
    tick();
    bus.wb_we    = 1'b0;
  endtask

  bit [6:0] opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

  initial begin
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = 32'd0;
    bus.if_pc    = 32'd0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 32'd0;
    exp_q        = '{default: 0};

    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    check("rst_Operand1",  bus.Operand1,       32'd0);
    check("rst_Operand2",  bus.Operand2,       32'd0);
    check("rst_Operation", 32'(bus.Operation), 32'd0);
    check("rst_ex_rd",     32'(bus.ex_rd),     32'd0);
    check("rst_ex_pc",     bus.ex_pc,          32'd0);
    check("rst_ex_imm",    bus.ex_imm,         32'd0);
    check("rst_ex_sd",     bus.ex_store_data,  32'd0);
    check("rst_ex_reg_we", 32'(bus.ex_reg_we), 32'd0);

    for (int r = 1; r < 32; r++) begin
      issue(r_add(5'd3, 5'(r), 5'(r)));
      check("rst_regread", bus.Operand1, 32'd0);
    end

    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h1234;
    issue(32'h00528313);
    bus.wb_we = 1'b0;
    check("byp_Operand1",  bus.Operand1,       32'h1234);
    check("byp_Operand2",  bus.Operand2,       32'd5);
    check("byp_Operation", 32'(bus.Operation), 32'd0);
    check("byp_ex_rd",     32'(bus.ex_rd),     32'd6);
    check("byp_reg_we",    32'(bus.ex_reg_we), 32'd1);
    issue(32'h00528313);
    check("rf_Operand1",   bus.Operand1,       32'h1234);

    wreg(5'd1, 32'h11);
    wreg(5'd2, 32'h22);
    issue(32'h402081B3);
    check("sub_Operation",  32'(bus.Operation), 32'd8);
    check("sub_Operand2",   bus.Operand2,       32'h22);
    issue(32'h4040D193);
    check("srai_Operation", 32'(bus.Operation), 32'd13);
    check("srai_Operand2",  bus.Operand2,       32'd4);
    issue(32'h0020E1B3);
    check("or_Operation",   32'(bus.Operation), 32'd3);
    issue(32'h0020D463);
    check("bge_Operation",  32'(bus.Operation), 32'd21);
    check("bge_imm",        bus.ex_imm,         32'd8);
    check("bge_reg_we",     32'(bus.ex_reg_we), 32'd0);
    check("model_bge_imm",  exp_q.imm,          32'd8);
    issue(32'hABCDE0B7);
    check("lui_Operation",  32'(bus.Operation), 32'd24);
    check("lui_Operand2",   bus.Operand2,       32'hABCDE000);
    issue(32'hFFC100E7);
    check("jalr_Operation", 32'(bus.Operation), 32'd25);
    check("jalr_Operand2",  bus.Operand2,       32'hFFFFFFFC);
    check("jalr_Operand1",  bus.Operand1,       32'h22);
    issue(32'h010000EF, 32'h100);
    check("jal_Operand1",   bus.Operand1,       32'h100);
    check("jal_Operand2",   bus.Operand2,       32'd4);
    check("jal_imm",        bus.ex_imm,         32'd16);
    check("jal_is_jal",     32'(bus.ex_is_jal), 32'd1);

    issue(32'h002081B3);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h99;
      issue(32'h402081B3 + 32'(k << 7), 32'h200);
      check("stall_Operation", 32'(bus.Operation), 32'd0);
      check("stall_Operand1",  bus.Operand1,       32'h11);
      check("stall_ex_rd",     32'(bus.ex_rd),     32'd3);
      check("stall_id_ready",  32'(bus.id_ready),  32'd0);
    end
    bus.wb_we = 1'b0;
    bus.flush = 1'b1;
    issue(32'h002081B3);
    check("sflush_valid",  32'(bus.ex_valid),  32'd0);
    check("sflush_reg_we", 32'(bus.ex_reg_we), 32'd0);
    bus.stall = 1'b0; bus.flush = 1'b0;
    issue(32'h002081B3);
    check("after_stall_Operand1", bus.Operand1, 32'h99);

    wreg(5'd0, 32'hFFFFFFFF);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    issue(32'h000000B3);
    bus.wb_we = 1'b0;
    check("x0_Operand1", bus.Operand1, 32'd0);
    check("x0_Operand2", bus.Operand2, 32'd0);

    issue(32'hFFFFFFFF);
    check("ill_valid",   32'(bus.ex_valid),   32'd1);
    check("ill_illegal", 32'(bus.ex_illegal), 32'd1);
    check("ill_enables", 32'({bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr, bus.ex_is_jal}), 32'd0);

    for (int n = 0; n < 2000; n++) begin
      bit [31:0] r   = $urandom();
      int        idx = int'($urandom_range(0, 9));
      bit [6:0]  opc = (idx == 9) ? 7'($urandom()) : opcs[idx];
      rst_n        = ($urandom_range(0, 99) != 0);
      bus.if_valid = ($urandom_range(0, 99) < 85);
      bus.if_instr = {r[31:7], opc};
      bus.if_pc    = $urandom() & 32'hFFFF_FFFC;
      bus.stall    = ($urandom_range(0, 99) < 20);
      bus.flush    = ($urandom_range(0, 99) < 8);
      bus.wb_we    = ($urandom_range(0, 1) == 1);
      bus.wb_rd    = ($urandom_range(0, 3) == 0) ? r[19:15] : 5'($urandom());
      bus.wb_data  = $urandom();
      tick();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
